// File: rtl/grid_commit_engine.sv
// Board-state owner for the 8x8 puzzle: validates a piece, merges it, scans
// all rows/columns for full lines, clears them together and keeps a saturating score.
module grid_commit_engine #(
    parameter int POINTS_PER_LINE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        place_valid,
    input  logic [63:0] place_mask,
    output logic        ready,
    output logic        done,
    output logic        result_ok,
    output logic [4:0]  lines_cleared,
    output logic [63:0] game_grid,
    output logic [7:0]  score
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] mask_q, mask_d;
    logic [63:0] grid_q, grid_d;
    logic [15:0] flags_q, flags_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  score_q, score_d;
    logic [4:0]  lines_q, lines_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;

    logic [4:0]  flagCount;
    logic [31:0] linePoints;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Sums run 33 bits wide so any increment clamps cleanly at 255.
    function automatic logic [7:0] satAdd(input logic [7:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {25'd0, base} + {1'b0, inc};
        return (sum > 33'd255) ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic lineFull(input logic [63:0] grid, input logic [3:0] idx);
        logic full;
        int   sel;
        sel  = int'(idx[2:0]);
        full = 1'b1;
        if (!idx[3]) begin
            full = &grid[sel*8 +: 8];
        end else begin
            for (int r = 0; r < 8; r++) begin
                full = full & grid[r*8 + sel];
            end
        end
        return full;
    endfunction

    function automatic logic [63:0] clearMask(input logic [15:0] flags);
        logic [63:0] m;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (flags[r] || flags[8 + c]) begin
                    m[r*8 + c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    assign flagCount  = popcount16(flags_q);
    assign linePoints = 32'(POINTS_PER_LINE) * 32'(flagCount);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            grid_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            lines_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            grid_q  <= grid_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lines_q <= lines_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        grid_d  = grid_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        lines_d = lines_q;
        done_d  = 1'b0;
        ok_d    = ok_q;

        unique case (state_q)
            IDLE: begin
                if (new_game) begin
                    grid_d  = '0;
                    score_d = '0;
                    lines_d = '0;
                end else if (place_valid) begin
                    mask_d  = place_mask;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((mask_q == 64'd0) || ((mask_q & grid_q) != 64'd0)) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    grid_d  = grid_q | mask_q;
                    score_d = satAdd(score_q, 32'(popcount64(mask_q)));
                    flags_d = '0;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            // One line per cycle: rows 0..7 first, then columns 0..7.
            SCAN: begin
                flags_d[cnt_q] = lineFull(grid_q, cnt_q);
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                grid_d  = grid_q & ~clearMask(flags_q);
                lines_d = flagCount;
                score_d = satAdd(score_q, linePoints);
                done_d  = 1'b1;
                ok_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready         = (state_q == IDLE);
    assign done          = done_q;
    assign result_ok     = ok_q;
    assign lines_cleared = lines_q;
    assign game_grid     = grid_q;
    assign score         = score_q;

endmodule

// File: tb/tb_grid_commit_engine.sv
// Directed self-checking bench for grid_commit_engine: commits, rejects,
// row/column crossing clears, score saturation and reset mid-scan.
module tb_grid_commit_engine;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic        place_valid;
    logic [63:0] place_mask;
    logic        ready;
    logic        done;
    logic        result_ok;
    logic [4:0]  lines_cleared;
    logic [63:0] game_grid;
    logic [7:0]  score;

    int checkCount = 0;
    int passCount  = 0;

    int          lat;
    logic [63:0] gridE1;
    logic [7:0]  scoreE1;

    grid_commit_engine #(.POINTS_PER_LINE(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .place_valid  (place_valid),
        .place_mask   (place_mask),
        .ready        (ready),
        .done         (done),
        .result_ok    (result_ok),
        .lines_cleared(lines_cleared),
        .game_grid    (game_grid),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Issues one request and waits (bounded) for done; lat=0 means no done seen.
    task automatic applyStimulus(input logic [63:0] mask, output int latency,
                                 output logic [63:0] g1, output logic [7:0] s1);
        place_valid = 1'b1;
        place_mask  = mask;
        waitCycle();
        place_valid = 1'b0;
        place_mask  = '0;
        latency     = 0;
        g1          = '0;
        s1          = '0;
        for (int i = 1; i <= 40; i++) begin
            waitCycle();
            if (i == 1) begin
                g1 = game_grid;
                s1 = score;
            end
            if (done) begin
                latency = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        new_game    = 1'b0;
        place_valid = 1'b0;
        place_mask  = '0;
        waitCycle();
        waitCycle();
        reset = 1'b0;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ok", result_ok, 0);
        checkOutput("rst_lines", lines_cleared, 0);
        checkOutput("rst_grid", game_grid, 0);
        checkOutput("rst_score", score, 0);

        applyStimulus(64'h7F, lat, gridE1, scoreE1);
        checkOutput("p7f_lat", lat, 18);
        checkOutput("p7f_gridE1", gridE1, 64'h7F);
        checkOutput("p7f_scoreE1", scoreE1, 7);
        checkOutput("p7f_ok", result_ok, 1);
        checkOutput("p7f_ready", ready, 1);
        checkOutput("p7f_grid", game_grid, 64'h7F);
        checkOutput("p7f_score", score, 7);
        checkOutput("p7f_lines", lines_cleared, 0);
        waitCycle();
        checkOutput("p7f_done_pulse", done, 0);

        applyStimulus(64'h80, lat, gridE1, scoreE1);
        checkOutput("row0_lat", lat, 18);
        checkOutput("row0_gridE1", gridE1, 64'hFF);
        checkOutput("row0_scoreE1", scoreE1, 8);
        checkOutput("row0_grid", game_grid, 0);
        checkOutput("row0_score", score, 16);
        checkOutput("row0_lines", lines_cleared, 1);

        applyStimulus(64'h0, lat, gridE1, scoreE1);
        checkOutput("empty_lat", lat, 1);
        checkOutput("empty_ok", result_ok, 0);
        checkOutput("empty_ready", ready, 1);
        checkOutput("empty_lines", lines_cleared, 1);
        checkOutput("empty_score", score, 16);

        applyStimulus(64'h1, lat, gridE1, scoreE1);
        checkOutput("p1_lat", lat, 18);
        checkOutput("p1_score", score, 17);
        applyStimulus(64'h1, lat, gridE1, scoreE1);
        checkOutput("ovl_lat", lat, 1);
        checkOutput("ovl_ok", result_ok, 0);
        checkOutput("ovl_grid", game_grid, 64'h1);
        checkOutput("ovl_score", score, 17);

        new_game    = 1'b1;
        place_valid = 1'b1;
        place_mask  = 64'hF0;
        waitCycle();
        new_game    = 1'b0;
        place_valid = 1'b0;
        checkOutput("ng_ready", ready, 1);
        checkOutput("ng_grid", game_grid, 0);
        checkOutput("ng_score", score, 0);
        checkOutput("ng_lines", lines_cleared, 0);
        waitCycle();
        checkOutput("ng_dropped_grid", game_grid, 0);
        checkOutput("ng_no_done", done, 0);

        applyStimulus(64'h0000_0000_F700_0000, lat, gridE1, scoreE1);
        checkOutput("x_row_score", score, 7);
        applyStimulus(64'h0808_0808_0008_0808, lat, gridE1, scoreE1);
        checkOutput("x_col_score", score, 14);
        checkOutput("x_col_lines", lines_cleared, 0);
        applyStimulus(64'h0000_0000_0800_0000, lat, gridE1, scoreE1);
        checkOutput("x_lat", lat, 18);
        checkOutput("x_gridE1", gridE1, 64'h0808_0808_FF08_0808);
        checkOutput("x_grid", game_grid, 0);
        checkOutput("x_lines", lines_cleared, 2);
        checkOutput("x_score", score, 31);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(64'hFF, lat, gridE1, scoreE1);
        end
        checkOutput("sat_pre_score", score, 239);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, lat, gridE1, scoreE1);
        checkOutput("sat_scoreE1", scoreE1, 255);
        checkOutput("sat_score", score, 255);
        checkOutput("sat_lines", lines_cleared, 16);
        checkOutput("sat_grid", game_grid, 0);

        place_valid = 1'b1;
        place_mask  = 64'h1;
        waitCycle();
        place_valid = 1'b0;
        waitCycle();
        checkOutput("busy_ready", ready, 0);
        new_game = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
        end
        new_game = 1'b0;
        checkOutput("busy_ng_grid", game_grid, 64'h1);
        checkOutput("busy_ng_score", score, 255);
        reset = 1'b1;
        waitCycle();
        reset = 1'b0;
        checkOutput("abort_ready", ready, 1);
        checkOutput("abort_grid", game_grid, 0);
        checkOutput("abort_score", score, 0);
        checkOutput("abort_lines", lines_cleared, 0);
        checkOutput("abort_done", done, 0);
        waitCycle();
        checkOutput("abort_done_later", done, 0);
        checkOutput("abort_ok", result_ok, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
